// File: rtl/bit_serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package bit_serial_adder_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// Single full-adder cell. The sum path is a two-stage XNOR, which is
// logically the same as a ^ b ^ cin.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = ~(~(a ^ b) ^ cin);
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one sum bit per clock through one fa_cell.
// Optional signed-overflow output is enabled by BIT_SERIAL_ADDER_OVERFLOW_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Input side accepts only in IDLE; the output side holds
// sum/cout (and ovf) stable in DONE until out_ready is seen.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    output logic             ovf,
`endif
    output state_t           state
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (count == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs; in_ready is forced low while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = ~rst;
            RUN:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand load in IDLE, then one shift/add step per clock in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_co;
                    count  <= count + CW'(1);
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
                    // On the MSB step, carry holds the carry into the MSB.
                    if (count == LAST) ovf <= carry ^ fa_co;
`endif
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_sh;
    assign cout = carry;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8). Build with
// BIT_SERIAL_ADDER_OVERFLOW_EN defined to also check the ovf output.
module tb_bit_serial_adder;
    import bit_serial_adder_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         ovf_obs;
    state_t       state;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
        .ovf       (ovf_obs),
`endif
        .state     (state)
    );

`ifndef BIT_SERIAL_ADDER_OVERFLOW_EN
    assign ovf_obs = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    // Entries are {ovf, cout, sum[7:0]}.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] obs_q[$];
    int checks   = 0;
    int failures = 0;

    // Record every completed output handshake (sampled mid-cycle).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs_q.push_back({ovf_obs, cout, sum});
    end

    // Reference: plain integer arithmetic, signed overflow from signed range.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int t;
        int s;
        t = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        model = {(s > 127 || s < -128), t[8:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare an observed result with an expected one.
    task automatic compare_result(input string name, input logic [W+1:0] got,
                                  input logic [W+1:0] exp);
        check({name, "_sum"}, 32'(got[W-1:0]), 32'(exp[W-1:0]));
        check({name, "_cout"}, 32'(got[W]), 32'(exp[W]));
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
        check({name, "_ovf"}, 32'(got[W+1]), 32'(exp[W+1]));
`endif
    endtask

    // ---------------- driver ----------------
    // One full transaction: wait for in_ready, present operands for one edge,
    // wait for out_valid, hold out_ready low for 'stall' cycles, then take it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input int stall, output int lat, output logic [W+1:0] got);
        int n;
        logic [W+1:0] exp;
        exp = model(ta, tb, tc);
        exp_q.push_back(exp);
        got = '0;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        out_ready = (stall == 0);
        step();
        // Scramble inputs after acceptance; they must have no effect.
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_sum", 32'(sum), 32'(exp[W-1:0]));
            check("stall_cout", 32'(cout), 32'(exp[W]));
            in_valid = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("state_after_handshake", 32'(state), 32'(IDLE));
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
        check("one_result_per_op", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) got = obs_q.pop_front();
        while (obs_q.size() > 0) void'(obs_q.pop_front());
        compare_result("model", got, exp_q.pop_front());
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        logic [W+1:0] got;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

        // Reset state.
        step(); step();
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Table vectors with out_ready held high.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, lat, got);
            check("vec_latency", 32'(lat), 32'(W));
            check("vec_sum", 32'(got[W-1:0]), 32'(vecs[i].sum));
            check("vec_cout", 32'(got[W]), 32'(vecs[i].cout));
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
            check("vec_ovf", 32'(got[W+1]), 32'(vecs[i].ovf));
`endif
        end

        // Backpressure: result held for 5 cycles, in_valid pulses ignored.
        run_op(8'h12, 8'h34, 1'b0, 5, lat, got);
        check("bp_sum", 32'(got[W-1:0]), 32'h46);
        check("bp_latency", 32'(lat), 32'(W));

        // Reset in the middle of RUN.
        step();
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("mid_run_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("abort_state", 32'(state), 32'(IDLE));
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_release", 32'(in_ready), 32'd1);
        check("abort_no_result", 32'(obs_q.size()), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 0, lat, got);
        check("post_abort_sum", 32'(got[W-1:0]), 32'h02);
        check("post_abort_latency", 32'(lat), 32'(W));

        // Random sweep with idle gaps and output stalls.
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), lat, got);
            check("rand_latency", 32'(lat), 32'(W));
        end

        step(); step();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("obs_q_empty", 32'(obs_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
